// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, line levels and receiver state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // Bit positions within an 11-bit frame (start, 8 data LSB first, parity, stop)
  localparam int unsigned FRAME_START_POS  = 0;
  localparam int unsigned FRAME_DATA_POS   = 1;
  localparam int unsigned FRAME_PARITY_POS = 9;
  localparam int unsigned FRAME_STOP_POS   = 10;
  localparam int unsigned FRAME_BITS       = 11;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreakWait
  } rx_state_e;

  // Parity bit a transmitter appends so the frame has the requested parity
  function automatic logic parity_bit(logic [UART_DATA_BITS-1:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic baud_clock,
  input  logic reset_n,
  input  logic serial_in,
  output logic s_in,
  output logic fall_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = serial_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Resetting to the idle level keeps a reset release from looking like a start edge
  always_ff @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      prev_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign s_in      = sync2_q;
  assign fall_edge = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: validates the start bit, samples each bit mid-period,
// checks parity/stop and holds the byte on a valid/ack handshake with sticky errors.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                      baud_clock,
  input  logic                      reset_n,
  input  logic                      serial_in,
  input  logic                      rx_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      is_receiving,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      overrun_error
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(UART_DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and at least 4");
  end

  logic s_in;
  logic fall_edge;

  uart_rx_sync u_sync (
    .baud_clock (baud_clock),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .s_in       (s_in),
    .fall_edge  (fall_edge)
  );

  rx_state_e state_q, state_d;

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      p_rx_q, p_rx_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      parity_error_q, parity_error_d;
  logic                      framing_error_q, framing_error_d;
  logic                      overrun_error_q, overrun_error_d;

  logic sample_tick;
  logic frame_done;
  logic ack_take;

  // FSM state register
  always_ff @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fall_edge) state_d = StStart;
      end
      StStart: begin
        if (sample_tick) state_d = s_in ? StIdle : StData;
      end
      StData: begin
        if (sample_tick && (bit_cnt_q == BitLast)) begin
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample_tick) state_d = StStop;
      end
      StStop: begin
        // A low stop bit may be a line break; wait for idle before hunting again
        if (sample_tick) state_d = s_in ? StIdle : StBreakWait;
      end
      StBreakWait: begin
        if (s_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    sample_tick  = 1'b0;
    is_receiving = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      StStart: begin
        sample_tick = (cnt_q == CntHalf);
      end
      StData, StParity: begin
        sample_tick  = (cnt_q == CntLast);
        is_receiving = 1'b1;
      end
      StStop: begin
        sample_tick  = (cnt_q == CntLast);
        is_receiving = 1'b1;
        frame_done   = sample_tick;
      end
      default: ;
    endcase
  end

  // Sample counter, bit counter and shift register
  always_comb begin
    cnt_d     = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_rx_d    = p_rx_q;
    case (state_q)
      StStart, StData, StParity, StStop: begin
        cnt_d = sample_tick ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (sample_tick) begin
      case (state_q)
        StStart:  bit_cnt_d = '0;
        StData: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = {s_in, shift_q[UART_DATA_BITS-1:1]};
        end
        StParity: p_rx_d = s_in;
        default: ;
      endcase
    end
  end

  // Handshake: an ack is applied before a frame completing in the same cycle
  always_comb begin
    ack_take        = rx_ack & rx_valid_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    overrun_error_d = overrun_error_q;
    if (ack_take) begin
      rx_valid_d      = 1'b0;
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
      overrun_error_d = 1'b0;
    end
    if (frame_done) begin
      if (rx_valid_d) begin
        overrun_error_d = 1'b1;
      end else begin
        rx_data_d       = shift_q;
        rx_valid_d      = 1'b1;
        parity_error_d  = PARITY_EN & (p_rx_q != parity_bit(shift_q, PARITY_ODD));
        framing_error_d = ~s_in;
      end
    end
  end

  always_ff @(posedge baud_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      p_rx_q          <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      p_rx_q          <= p_rx_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: table of directed and random frames checked
// against a transaction-level model, plus hand-written glitch and reset sequences.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  localparam int unsigned OS = 16;
  localparam bit          PE = 1'b1;
  localparam bit          PO = 1'b0;
  localparam int          NB = PE ? 11 : 10;
  localparam int          NDIR = 6;
  localparam int          NRND = 14;
  localparam int          NVEC = NDIR + NRND;

  logic       baud_clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       serial_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       is_receiving;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;

  uart_rx_sipo #(
    .OVERSAMPLE (OS),
    .PARITY_EN  (PE),
    .PARITY_ODD (PO)
  ) dut (
    .baud_clock    (baud_clock),
    .reset_n       (reset_n),
    .serial_in     (serial_in),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .is_receiving  (is_receiving),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  always #5 baud_clock = ~baud_clock;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    int         hold_bits;
    bit         ack;
    bit         lat_chk;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_oerr;
  } vec_t;

  vec_t vecs[NVEC];

  int checks = 0;
  int errors = 0;

  // Transaction-level model of what the consumer sees
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_perr, m_ferr, m_oerr;

  function automatic vec_t mk(logic [7:0] d, bit bp, bit st, int hold, bit ack);
    vec_t v;
    v.data = d; v.bad_par = bp; v.stop = st; v.hold_bits = hold; v.ack = ack;
    v.lat_chk = 1'b0; v.exp_valid = 1'b0; v.exp_data = '0;
    v.exp_perr = 1'b0; v.exp_ferr = 1'b0; v.exp_oerr = 1'b0;
    return v;
  endfunction

  // Parity bit placed on the wire: correct one, optionally inverted
  function automatic bit tx_parity(logic [7:0] d, bit bad);
    return bit'(($countones(d) + int'(PO)) % 2) ^ bad;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
  endtask

  task automatic model_frame(logic [7:0] d, bit p, bit stop);
    if (m_valid) begin
      m_oerr = 1'b1;
    end else begin
      m_valid = 1'b1;
      m_data  = d;
      m_perr  = PE && ((($countones(d) + int'(p)) % 2) != int'(PO));
      m_ferr  = !stop;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge baud_clock);
  endtask

  // Drives one frame (plus optional held-low break bits); cut>0 stops early
  task automatic send_frame(input logic [7:0] d, input bit p, input bit stop, input int hold,
                            input int cut, output int lat, output int rcv);
    bit v0;
    int idx;
    v0  = rx_valid;
    lat = -1;
    rcv = 0;
    for (int i = 0; i < (NB + hold) * int'(OS); i++) begin
      idx = i / int'(OS);
      if (idx == 0)                serial_in = 1'b0;
      else if (idx <= 8)           serial_in = d[idx-1];
      else if (PE && idx == 9)     serial_in = p;
      else if (idx == NB - 1)      serial_in = stop;
      else                         serial_in = 1'b0;
      @(negedge baud_clock);
      if (!v0 && rx_valid && lat < 0) lat = i;
      if (is_receiving) rcv++;
      if (cut > 0 && i + 1 == cut) return;
    end
    serial_in = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge baud_clock);
    rx_ack = 1'b0;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
    if (m_valid) chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, "_perr"}, 32'(parity_error), 32'(m_perr));
    chk({tag, "_ferr"}, 32'(framing_error), 32'(m_ferr));
    chk({tag, "_oerr"}, 32'(overrun_error), 32'(m_oerr));
  endtask

  // Latency: ~(9.5+PE)*OS+3 cycles from the line falling edge
  localparam int LatNom = ((19 + 2 * int'(PE)) * int'(OS)) / 2 + 3;

  initial begin
    int lat, rcv, seen;
    bit p;
    string tag;

    // Directed vectors: clean, bad parity, break, overrun pair, clean
    vecs[0] = mk(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    vecs[1] = mk(8'h3C, 1'b1, 1'b1, 0, 1'b1);
    vecs[2] = mk(8'h81, 1'b0, 1'b0, 3, 1'b1);
    vecs[3] = mk(8'h11, 1'b0, 1'b1, 0, 1'b0);
    vecs[4] = mk(8'h22, 1'b0, 1'b1, 0, 1'b1);
    vecs[5] = mk(8'h33, 1'b0, 1'b1, 0, 1'b1);
    for (int i = NDIR; i < NVEC; i++) begin
      bit st;
      st = ($urandom_range(5) != 0);
      vecs[i] = mk(8'($urandom), ($urandom_range(3) == 0), st,
                   st ? 0 : int'($urandom_range(3, 1)), ($urandom_range(3) != 0));
    end
    vecs[NVEC-1].ack = 1'b1;

    model_reset();
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].lat_chk = !m_valid;
      model_frame(vecs[i].data, tx_parity(vecs[i].data, vecs[i].bad_par), vecs[i].stop);
      vecs[i].exp_valid = m_valid;
      vecs[i].exp_data  = m_data;
      vecs[i].exp_perr  = m_perr;
      vecs[i].exp_ferr  = m_ferr;
      vecs[i].exp_oerr  = m_oerr;
      if (vecs[i].ack) model_ack();
    end

    // Reset
    #2 reset_n = 1'b0;
    idle(3);
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_recv", 32'(is_receiving), 0);
    chk("reset_errs", {29'd0, parity_error, framing_error, overrun_error}, 0);
    reset_n = 1'b1;
    idle(OS);

    for (int i = 0; i < NVEC; i++) begin
      tag = $sformatf("vec%0d", i);
      p = tx_parity(vecs[i].data, vecs[i].bad_par);
      send_frame(vecs[i].data, p, vecs[i].stop, vecs[i].hold_bits, 0, lat, rcv);
      idle(2 * OS);
      chk({tag, "_valid"}, 32'(rx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk({tag, "_data"}, 32'(rx_data), 32'(vecs[i].exp_data));
      chk({tag, "_perr"}, 32'(parity_error), 32'(vecs[i].exp_perr));
      chk({tag, "_ferr"}, 32'(framing_error), 32'(vecs[i].exp_ferr));
      chk({tag, "_oerr"}, 32'(overrun_error), 32'(vecs[i].exp_oerr));
      chk({tag, "_recv_end"}, 32'(is_receiving), 0);
      chk_range({tag, "_recv_cycles"}, rcv, int'(OS) * (NB - 1) - 10, int'(OS) * (NB - 1) + 10);
      if (vecs[i].lat_chk) chk_range({tag, "_latency"}, lat + 1, LatNom - 3, LatNom + 3);
      if (vecs[i].ack) begin
        ack_pulse();
        chk({tag, "_ack_valid"}, 32'(rx_valid), 0);
        chk({tag, "_ack_errs"}, {29'd0, parity_error, framing_error, overrun_error}, 0);
      end
    end

    // Short low glitch must not start a frame
    model_reset();
    serial_in = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge baud_clock);
      if (is_receiving) seen = 1;
    end
    serial_in = 1'b1;
    repeat (2 * OS) begin
      @(negedge baud_clock);
      if (is_receiving) seen = 1;
    end
    chk("glitch_recv", 32'(seen), 0);
    chk("glitch_valid", 32'(rx_valid), 0);

    p = tx_parity(8'h55, 1'b0);
    send_frame(8'h55, p, 1'b1, 0, 0, lat, rcv);
    model_frame(8'h55, p, 1'b1);
    idle(2 * OS);
    check_model("post_glitch");
    chk_range("post_glitch_latency", lat + 1, LatNom - 3, LatNom + 3);
    ack_pulse();
    model_ack();
    check_model("post_glitch_ack");

    // Held bad-parity frame, then reset midway through data bit 4 of the next one
    p = tx_parity(8'h5A, 1'b1);
    send_frame(8'h5A, p, 1'b1, 0, 0, lat, rcv);
    model_frame(8'h5A, p, 1'b1);
    idle(2 * OS);
    check_model("pre_reset");
    send_frame(8'hF0, tx_parity(8'hF0, 1'b0), 1'b1, 0, 5 * int'(OS) + int'(OS) / 2, lat, rcv);
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(rx_valid), 0);
    chk("midreset_data", 32'(rx_data), 0);
    chk("midreset_recv", 32'(is_receiving), 0);
    chk("midreset_errs", {29'd0, parity_error, framing_error, overrun_error}, 0);
    model_reset();
    serial_in = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(2 * OS);
    p = tx_parity(8'h0F, 1'b0);
    send_frame(8'h0F, p, 1'b1, 0, 0, lat, rcv);
    model_frame(8'h0F, p, 1'b1);
    idle(2 * OS);
    check_model("post_reset");
    chk_range("post_reset_latency", lat + 1, LatNom - 3, LatNom + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
